// File: rtl/collision_detect_if.sv
// Sprite/frame inputs and game-status outputs of the collision detector.
// The master side is the video/keyboard/controller environment; the slave side is the detector.
interface collision_detect_if;
  logic       frame_clk;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       ball_on;
  logic       obstacle_on;
  logic [7:0] keycode;
  logic       die_reset;
  logic       dead;
  logic       game_over;
  logic       invuln;
  logic [2:0] lives;

  modport master (
    output frame_clk, DrawX, DrawY, ball_on, obstacle_on, keycode, die_reset,
    input  dead, game_over, invuln, lives
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, ball_on, obstacle_on, keycode, die_reset,
    output dead, game_over, invuln, lives
  );
endinterface

// File: rtl/collision_detect.sv
// Confirms ball/obstacle collisions that persist across frames, raises dead until
// acknowledged, and tracks lives, respawn invulnerability and game-over.
module collision_detect #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned HIT_FRAMES   = 2,
  parameter int unsigned GRACE_FRAMES = 60,
  parameter logic [7:0]  RESTART_KEY  = 8'h2C,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480
) (
  input logic              Clk,
  input logic              Reset,
  collision_detect_if.slave bus
);

  typedef enum logic [1:0] {PLAY, DEAD, RESPAWN, OVER} state_t;

  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]  GRACE_INIT = 8'(GRACE_FRAMES);
  localparam logic [4:0]  HIT_NEED   = 5'(HIT_FRAMES);
  localparam logic [10:0] H_LIM      = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM      = 11'(V_ACTIVE);

  state_t     state, state_n;
  logic       dead_q, dead_n;
  logic       over_q, over_n;
  logic       inv_q, inv_n;
  logic [2:0] lives_q, lives_n;
  logic [3:0] hit_frames, hit_frames_n;
  logic [7:0] grace_cnt, grace_cnt_n;
  logic       overlap_flag, overlap_flag_n;
  logic       frame_clk_d;
  logic       tick;
  logic       ov;
  logic [4:0] hit_inc;

  always_comb begin
    tick    = bus.frame_clk & ~frame_clk_d;
    ov      = bus.ball_on & bus.obstacle_on &
              ({1'b0, bus.DrawX} < H_LIM) & ({1'b0, bus.DrawY} < V_LIM) &
              (state == PLAY);
    hit_inc = {1'b0, hit_frames} + 5'd1;

    state_n        = state;
    dead_n         = dead_q;
    over_n         = over_q;
    inv_n          = inv_q;
    lives_n        = lives_q;
    hit_frames_n   = hit_frames;
    grace_cnt_n    = grace_cnt;
    // A pixel overlapping on the tick cycle itself belongs to the frame that starts there.
    overlap_flag_n = tick ? ov : (overlap_flag | ov);

    case (state)
      PLAY: begin
        dead_n = 1'b0;
        if (tick) begin
          if (overlap_flag) begin
            if (hit_inc >= HIT_NEED) begin
              state_n      = DEAD;
              dead_n       = 1'b1;
              lives_n      = (lives_q == 3'd0) ? 3'd0 : 3'(lives_q - 3'd1);
              hit_frames_n = 4'd0;
            end else begin
              hit_frames_n = (hit_inc > 5'd15) ? 4'd15 : hit_inc[3:0];
            end
          end else begin
            hit_frames_n = 4'd0;
          end
        end
      end
      DEAD: begin
        if (bus.die_reset) begin
          dead_n = 1'b0;
          if (lives_q == 3'd0) begin
            state_n = OVER;
            over_n  = 1'b1;
          end else begin
            state_n     = RESPAWN;
            grace_cnt_n = GRACE_INIT;
            inv_n       = 1'b1;
          end
        end
      end
      RESPAWN: begin
        if (tick) begin
          grace_cnt_n = 8'(grace_cnt - 8'd1);
          if (grace_cnt == 8'd1) begin
            state_n        = PLAY;
            inv_n          = 1'b0;
            overlap_flag_n = 1'b0;
          end
        end
      end
      OVER: begin
        dead_n = 1'b0;
        if (bus.keycode == RESTART_KEY) begin
          state_n     = RESPAWN;
          lives_n     = LIVES_INIT;
          grace_cnt_n = GRACE_INIT;
          over_n      = 1'b0;
          inv_n       = 1'b1;
        end
      end
      default: begin
        state_n = PLAY;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= PLAY;
      dead_q       <= 1'b0;
      over_q       <= 1'b0;
      inv_q        <= 1'b0;
      lives_q      <= LIVES_INIT;
      hit_frames   <= 4'd0;
      grace_cnt    <= 8'd0;
      overlap_flag <= 1'b0;
      frame_clk_d  <= 1'b0;
    end else begin
      state        <= state_n;
      dead_q       <= dead_n;
      over_q       <= over_n;
      inv_q        <= inv_n;
      lives_q      <= lives_n;
      hit_frames   <= hit_frames_n;
      grace_cnt    <= grace_cnt_n;
      overlap_flag <= overlap_flag_n;
      frame_clk_d  <= bus.frame_clk;
    end
  end

  assign bus.dead      = dead_q;
  assign bus.game_over = over_q;
  assign bus.invuln    = inv_q;
  assign bus.lives     = lives_q;

endmodule
